// File: rtl/alu_exec_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_responder_if
// Purpose  : Request/response handshake bundle for the ALU execution responder.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_responder_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] inreg1;
    logic [7:0] inreg2;
    logic [1:0] opcode;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [7:0] resp_tag;

    modport master (
        output req_valid, inreg1, inreg2, opcode, resp_ready,
        input  req_ready, resp_valid, result, carry, zero, resp_tag
    );

    modport slave (
        input  req_valid, inreg1, inreg2, opcode, resp_ready,
        output req_ready, resp_valid, result, carry, zero, resp_tag
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_responder.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_responder
// Purpose  : Single-outstanding 8-bit ALU (add/sub/and/or) with tagged response.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_responder (
    input  logic                       clk,
    input  logic                       reset,
    alu_exec_responder_if.slave        bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [1:0] r_op;
    logic [7:0] r_count;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic [7:0] r_tag;

    logic       w_accept;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_res;
    logic       w_cy;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.req_valid)  w_next_state = S_EXEC;
            S_EXEC:                      w_next_state = S_RESP;
            S_RESP:  if (bus.resp_ready) w_next_state = S_IDLE;
            default:                     w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready  = (r_state == S_IDLE);
        bus.resp_valid = (r_state == S_RESP);
        bus.result     = r_result;
        bus.carry      = r_carry;
        bus.zero       = r_zero;
        bus.resp_tag   = r_tag;
    end

    // Subtract is A + ~B + 1; a clear bit 8 means a borrow occurred.
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} + {1'b0, ~r_b} + 9'd1;

    always_comb begin
        w_res = r_a | r_b;
        w_cy  = 1'b0;
        case (r_op)
            C_OP_ADD: begin
                w_res = w_sum[7:0];
                w_cy  = w_sum[8];
            end
            C_OP_SUB: begin
                w_res = w_diff[7:0];
                w_cy  = ~w_diff[8];
            end
            C_OP_AND: w_res = r_a & r_b;
            default:  w_res = r_a | r_b;
        endcase
    end

    // Operand capture on accept; the counter already holds this transaction's tag by EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_op     <= 2'd0;
            r_count  <= 8'd0;
            r_result <= 8'd0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_tag    <= 8'd0;
        end else begin
            if (w_accept) begin
                r_a     <= bus.inreg1;
                r_b     <= bus.inreg2;
                r_op    <= bus.opcode;
                r_count <= r_count + 8'd1;
            end
            if (r_state == S_EXEC) begin
                r_result <= w_res;
                r_carry  <= w_cy;
                r_zero   <= (w_res == 8'h00);
                r_tag    <= r_count;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_responder
// Purpose  : Self-checking bench: directed vector table, corner sequences, random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_responder;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   model_count;

    alu_exec_responder_if bus ();

    alu_exec_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic       c;
        logic       z;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU built from plain integer arithmetic: returns {carry, result}.
    function automatic logic [8:0] ref_alu(input int a, input int b, input int op);
        int r;
        bit c;
        c = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); r = r % 256; end
            1: begin c = (a < b); r = (a - b + 256) % 256; end
            2: r = a & b;
            default: r = a | b;
        endcase
        return {c, 8'(r)};
    endfunction

    // One full transaction from IDLE: accept, response, optional backpressure, handshake.
    task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                          input int hold, output logic [7:0] o_res, output logic o_c,
                          output logic o_z);
        logic [8:0] exp;
        int         n;
        bus.req_valid = 1'b1;
        bus.inreg1    = a;
        bus.inreg2    = b;
        bus.opcode    = op;
        @(posedge clk); #1;
        check("accept_ready_low", {31'd0, bus.req_ready}, 32'd0);
        model_count = (model_count + 1) % 256;
        exp = ref_alu(int'(a), int'(b), int'(op));
        bus.req_valid  = 1'b0;
        bus.inreg1     = 8'($urandom);
        bus.inreg2     = 8'($urandom);
        bus.opcode     = 2'($urandom);
        bus.resp_ready = 1'($urandom);
        n = 0;
        while (!bus.resp_valid && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 1);
        if (hold > 0) bus.resp_ready = 1'b0;
        check("result", {24'd0, bus.result}, {24'd0, exp[7:0]});
        check("carry", {31'd0, bus.carry}, {31'd0, exp[8]});
        check("zero", {31'd0, bus.zero}, {31'd0, exp[7:0] == 8'h00});
        check("tag", {24'd0, bus.resp_tag}, model_count);
        o_res = bus.result;
        o_c   = bus.carry;
        o_z   = bus.zero;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'($urandom);
            bus.inreg1    = 8'($urandom);
            bus.opcode    = 2'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
            check("hold_ready", {31'd0, bus.req_ready}, 32'd0);
            check("hold_result", {15'd0, bus.carry, bus.result, bus.resp_tag},
                  {15'd0, exp[8], exp[7:0], 8'(model_count)});
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        check("post_hs_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("post_hs_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] r;
        logic       c;
        logic       z;

        tbl[0] = '{a: 8'd8,   b: 8'd5, op: 2'b00, res: 8'd13,  c: 1'b0, z: 1'b0};
        tbl[1] = '{a: 8'd8,   b: 8'd5, op: 2'b01, res: 8'd3,   c: 1'b0, z: 1'b0};
        tbl[2] = '{a: 8'd8,   b: 8'd5, op: 2'b10, res: 8'd0,   c: 1'b0, z: 1'b1};
        tbl[3] = '{a: 8'd8,   b: 8'd5, op: 2'b11, res: 8'd13,  c: 1'b0, z: 1'b0};
        tbl[4] = '{a: 8'd255, b: 8'd1, op: 2'b00, res: 8'd0,   c: 1'b1, z: 1'b1};
        tbl[5] = '{a: 8'd5,   b: 8'd8, op: 2'b01, res: 8'hFD,  c: 1'b1, z: 1'b0};
        tbl[6] = '{a: 8'd200, b: 8'd200, op: 2'b01, res: 8'd0, c: 1'b0, z: 1'b1};

        checks = 0;
        errors = 0;
        model_count = 0;
        bus.req_valid  = 1'b0;
        bus.inreg1     = 8'd0;
        bus.inreg2     = 8'd0;
        bus.opcode     = 2'd0;
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        #12;
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_outputs", {14'd0, bus.carry, bus.zero, bus.result, bus.resp_tag}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_txn(tbl[i].a, tbl[i].b, tbl[i].op, 0, r, c, z);
            check("tbl_result", {24'd0, r}, {24'd0, tbl[i].res});
            check("tbl_carry", {31'd0, c}, {31'd0, tbl[i].c});
            check("tbl_zero", {31'd0, z}, {31'd0, tbl[i].z});
        end

        // Backpressure: 10 stalled cycles with inputs toggling, then one handshake.
        do_txn(8'd77, 8'd33, 2'b01, 10, r, c, z);
        @(posedge clk); #1;
        check("idle_after_bp", {30'd0, bus.req_ready, bus.resp_valid}, 32'd2);

        // Reset in the middle of EXEC aborts the transaction.
        bus.req_valid = 1'b1;
        bus.inreg1    = 8'd9;
        bus.inreg2    = 8'd9;
        bus.opcode    = 2'b00;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("midrst_tag", {24'd0, bus.resp_tag}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_no_resp", {31'd0, bus.resp_valid}, 32'd0);
        end
        do_txn(8'd8, 8'd5, 2'b00, 0, r, c, z);

        for (int i = 0; i < 40; i++) begin
            do_txn(8'($urandom), 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)), r, c, z);
        end

        // Tag wrap: from reset, the 256th response carries tag 0.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_count = 0;
        for (int i = 0; i < 256; i++) begin
            do_txn(8'($urandom), 8'($urandom), 2'($urandom), 0, r, c, z);
        end
        check("wrap_tag_zero", {24'd0, bus.resp_tag}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_exec_responder.md
ALU_EXEC_RESPONDER -- requirements
Module: alu_exec_responder

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits, opcode width fixed at 2 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 req_valid  input  1  requester presents operands and opcode this cycle.
REQ-005 inreg1  input  8  operand A, unsigned.
REQ-006 inreg2  input  8  operand B, unsigned.
REQ-007 opcode  input  2  00 add, 01 sub (A-B), 10 bitwise AND, 11 bitwise OR.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 resp_valid  output  1  result, carry, zero and tag are valid.
REQ-010 resp_ready  input  1  consumer accepts the response this cycle.
REQ-011 result  output  8  registered ALU result.
REQ-012 carry  output  1  add: carry-out; sub: borrow (1 when A<B); logic ops: 0.
REQ-013 zero  output  1  1 when result == 8'h00.
REQ-014 resp_tag  output  8  transaction count of this response, wraps 255->0.

Function
REQ-015 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-016 IDLE: req_ready=1, resp_valid=0; req_valid=1 latches inreg1, inreg2, opcode into internal registers and moves to EXEC.
REQ-017 Inputs are sampled only on the accept edge; changes to inreg1/inreg2/opcode after accept do not affect the in-flight result.
REQ-018 EXEC: req_ready=0, resp_valid=0; computes on latched operands, registers result/carry/zero/resp_tag, moves to RESP after exactly one cycle.
REQ-019 Latency: resp_valid rises 2 rising edges after the accepting edge.
REQ-020 Add/sub use 9-bit arithmetic; result = low 8 bits, carry/borrow = bit 8 (sub borrow = inverted 9th bit of A+~B+1).
REQ-021 RESP: resp_valid=1, req_ready=0; result, carry, zero, resp_tag held stable until handshake.
REQ-022 RESP with resp_ready=1: response consumed, return to IDLE; resp_valid=0 next cycle.
REQ-023 RESP with resp_ready=0: remain in RESP indefinitely, outputs unchanged.
REQ-024 Throughput: one transaction per 3 cycles minimum; no back-to-back accept without passing through IDLE.
REQ-025 req_valid while req_ready=0 is ignored; no request queued.
REQ-026 Transaction counter increments by 1 on each accept; resp_tag = counter value after increment (first response tag = 1); 255 wraps to 0.
REQ-027 resp_ready asserted while resp_valid=0 has no effect.

Reset
REQ-028 reset asserted asynchronously forces state IDLE, req_ready=1, resp_valid=0, result=0, carry=0, zero=0, resp_tag=0, counter=0, latched operands=0.
REQ-029 Reset during EXEC or RESP aborts the transaction; no response is produced for it.
REQ-030 After reset deasserts, first rising edge with req_valid=1 accepts normally.

Verification
REQ-031 Add: A=8, B=5, op=00, resp_ready=1 -> resp_valid 2 edges after accept, result=13, carry=0, zero=0, resp_tag=1.
REQ-032 Opcode sweep with A=8, B=5, ops 00..11 sequentially -> results 13, 3, 0 (zero=1), 13; tags 1..4.
REQ-033 Boundaries: A=255,B=1 add -> result=0, carry=1, zero=1; A=5,B=8 sub -> result=8'hFD, carry=1.
REQ-034 Backpressure: hold resp_ready=0 for 10 cycles in RESP, toggle inreg1/opcode -> outputs stable, req_ready=0; release -> single handshake, IDLE next cycle.
REQ-035 Reset mid-EXEC: assert reset between edges -> resp_valid=0, req_ready=1 immediately; next accept gives resp_tag=1.
REQ-036 Tag wrap: 256 consecutive transactions -> 256th response resp_tag=0.
